ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter AW, default 32: HADDR width.
REQ-002 SHALL have parameter DW, default 32: data width, restricted to 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 64: number of DW-bit words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, range 0..15: wait states per data phase.
REQ-005 SHALL use one clock and an asynchronous active-low reset, as listed in REQ-006 and REQ-007.
REQ-006 SHALL have port HCLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 SHALL have port HRESETN, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port HSEL, input, 1 bit: slave select.
REQ-009 SHALL have port HADDR, input, AW bits: byte address.
REQ-010 SHALL have port HTRANS, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 SHALL have port HWRITE, input, 1 bit: 1=write, 0=read.
REQ-012 SHALL have port HSIZE, input, 3 bits: transfer size, 2^HSIZE bytes.
REQ-013 SHALL have port HBURST, input, 3 bits: accepted and ignored, because addresses arrive per beat.
REQ-014 SHALL have port HWSTRB, input, DW/8 bits: byte-lane write strobes.
REQ-015 SHALL have port HWDATA, input, DW bits: write data, valid in the data phase.
REQ-016 SHALL have port HREADY, input, 1 bit: bus-wide ready.
REQ-017 SHALL have port HRDATA, output, DW bits: read data.
REQ-018 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-019 SHALL have port HRESP, output, 1 bit: 0=OKAY, 1=ERROR.
REQ-020 SHALL have port err_cnt, output, 16 bits: saturating count of ERROR responses.

Function
REQ-021 SHALL sample an address phase when HSEL & HREADY & HTRANS[1] is 1; it SHALL register address, HWRITE, HSIZE and the lane mask.
REQ-022 SHALL treat IDLE or BUSY, or HSEL=0, with HREADY=1 as no transfer: zero-wait OKAY, next state S_IDLE.
REQ-023 SHALL detect an error when any of these holds: word index (HADDR / (DW/8)) >= MEM_DEPTH; HSIZE > log2(DW/8); HADDR not aligned to 2^HSIZE.
REQ-024 SHALL implement states with these outputs (HREADYOUT/HRESP): S_IDLE 1/0, S_WAIT 0/0, S_DATA 1/0, S_ERR1 0/1, S_ERR2 1/1.
REQ-025 SHALL, from S_IDLE, S_DATA or S_ERR2, go on a sampled error-free transfer to S_DATA if WAIT_CYCLES=0, else to S_WAIT with wcnt=WAIT_CYCLES-1.
REQ-026 SHALL, from S_IDLE, S_DATA or S_ERR2, go to S_ERR1 on a sampled erroneous transfer, and to S_IDLE when no transfer is sampled.
REQ-027 SHALL, in S_WAIT, go to S_DATA when wcnt=0, else decrement wcnt (4-bit); HREADYOUT is therefore low for exactly WAIT_CYCLES cycles.
REQ-028 SHALL always go from S_ERR1 to S_ERR2; an erroneous transfer SHALL never modify memory.
REQ-029 SHALL write memory at the end of the S_DATA cycle, for writes only; byte lane b is written when HWSTRB[b] & lane_mask[b] is 1.
REQ-030 SHALL set lane_mask to the 2^HSIZE lanes starting at HADDR mod (DW/8).
REQ-031 SHALL drive HRDATA in S_DATA of a read as the full word mem[index], combinationally from the array, and drive it to zero in all other states.
REQ-032 SHALL return new data for a read whose data phase follows a write's S_DATA to the same word (write-then-read).
REQ-033 SHALL sample a new address phase in the S_DATA or S_ERR2 cycle; pipelined back-to-back transfers SHALL not insert extra idle cycles.
REQ-034 SHALL increment err_cnt on entry to S_ERR1 and hold it at 16'hFFFF once reached.
REQ-035 SHALL not act on HTRANS, HSEL or HWDATA while HREADY=0 in S_IDLE; that case is an external wait and the state holds.

Reset
REQ-036 SHALL, while HRESETN=0, force: state S_IDLE, wcnt=0, HREADYOUT=1, HRESP=0, HRDATA=0, err_cnt=0, address/control registers 0.
REQ-037 SHALL discard an in-flight write on reset mid-operation, and SHALL not reset memory contents.

Verification (DW=32, MEM_DEPTH=64, WAIT_CYCLES=2)
REQ-038 SHALL cover: NONSEQ word write 0x10 = 0xA5A51234 with HWSTRB=0xF, then read 0x10 -> HREADYOUT low 2 cycles in each data phase, HRDATA=0xA5A51234, HRESP=0.
REQ-039 SHALL cover: byte write HSIZE=0 to 0x13 with HWDATA=0xEE000000, then read 0x10 -> 0xEEA51234.
REQ-040 SHALL cover: write to 0x100 (index 64) -> S_ERR1 (HREADYOUT=0, HRESP=1), then S_ERR2 (1/1), memory unchanged, err_cnt=1.
REQ-041 SHALL cover: halfword write to 0x11 -> two-cycle ERROR, err_cnt increments to 2, no lane written.
REQ-042 SHALL cover: INCR4 write 0x20..0x2C with one BUSY beat inserted after beat 2 -> BUSY beat gets zero-wait OKAY; all four words read back correctly.
REQ-043 SHALL cover: HRESETN pulsed low while in S_WAIT of a write to 0x30 -> HREADYOUT=1, HRESP=0 immediately; readback of 0x30 shows the old value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: DW-bit word array with byte-lane writes, programmable
// wait states and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETN,
  input  logic            HSEL,
  input  logic [AW-1:0]   HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [DW/8-1:0] HWSTRB,
  input  logic [DW-1:0]   HWDATA,
  input  logic            HREADY,
  output logic [DW-1:0]   HRDATA,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [15:0]     err_cnt
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    wcnt_reg, wcnt_next;
  logic [IW-1:0] idx_reg;
  logic [NB-1:0] lane_reg, lane_next;
  logic          write_reg;
  logic [15:0]   err_cnt_reg;
  logic [DW-1:0] mem [MEM_DEPTH];

  logic          sample;
  logic          take;
  logic          addr_err;
  logic [LB-1:0] addr_off;
  logic [8:0]    size_bytes;
  logic [AW-1:0] align_mask;
  logic          unused_inputs;

  // Burst type carries no information here: every beat presents its own address.
  assign unused_inputs = ^HBURST;

  assign sample     = HSEL & HREADY & HTRANS[1];
  assign addr_off   = HADDR[LB-1:0];
  assign size_bytes = 9'd1 << HSIZE;
  assign align_mask = AW'(size_bytes) - AW'(1);
  assign addr_err   = ((HADDR >> LB) >= AW'(MEM_DEPTH)) ||
                      (HSIZE > 3'(LB)) ||
                      ((HADDR & align_mask) != '0);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_next[gi] = (gi >= int'(addr_off)) &&
                           (gi < int'(addr_off) + int'(size_bytes));
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    take       = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state_reg)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wcnt_reg == 4'd0) state_next = S_DATA;
        else                  wcnt_next  = wcnt_reg - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      S_IDLE, S_DATA, S_ERR2: begin
        // These are the only states that can accept a new (pipelined) address phase.
        HRESP = (state_reg == S_ERR2);
        if (sample) begin
          take = 1'b1;
          if (addr_err) begin
            state_next = S_ERR1;
          end else if (WAIT_CYCLES == 0) begin
            state_next = S_DATA;
          end else begin
            state_next = S_WAIT;
            wcnt_next  = WAIT_LOAD;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_reg   <= S_IDLE;
      wcnt_reg    <= 4'd0;
      idx_reg     <= '0;
      lane_reg    <= '0;
      write_reg   <= 1'b0;
      err_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (take) begin
        idx_reg   <= HADDR[LB +: IW];
        lane_reg  <= lane_next;
        write_reg <= HWRITE;
      end
      if (state_next == S_ERR1 && err_cnt_reg != 16'hFFFF)
        err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  // Contents survive reset; reset only kills the write by leaving S_DATA unreachable.
  always_ff @(posedge HCLK) begin
    if (state_reg == S_DATA && write_reg) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b] && lane_reg[b]) mem[idx_reg][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA  = (state_reg == S_DATA && !write_reg) ? mem[idx_reg] : '0;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a pipelined AHB master replays a beat queue and
// compares every cycle against a byte-addressed reference memory and response-timing model.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
  localparam int WAITS = 2;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, ext_ready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hwstrb;
  logic        hready, hreadyout, hresp;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;
  assign hready = hreadyout & ext_ready;

  ahb_sram_slave #(.AW(32), .DW(32), .MEM_DEPTH(64), .WAIT_CYCLES(WAITS)) dut (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWSTRB(hwstrb), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .err_cnt(err_cnt)
  );

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } beat_t;

  beat_t      q[$];
  logic [7:0] mem_b [256];
  int         model_err;
  int         n_checks;
  int         n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic beat_t mk(input bit sel, input logic [1:0] trans, input bit write,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] burst);
    beat_t b;
    b.sel = sel; b.trans = trans; b.write = write; b.addr = addr;
    b.size = size; b.wdata = wdata; b.strb = strb; b.burst = burst;
    return b;
  endfunction

  function automatic beat_t idle_beat();
    return mk(1'b0, T_IDLE, 1'b0, 32'd0, 3'd0, 32'd0, 4'd0, 3'd0);
  endfunction

  function automatic bit is_xfer(input beat_t b);
    return b.sel && b.trans[1];
  endfunction

  function automatic bit is_err(input beat_t b);
    return (b.addr / 4 >= 64) || (b.size > 3'd2) || ((b.addr % (32'd1 << b.size)) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int base;
    base = int'(addr / 4) * 4;
    return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
  endfunction

  task automatic model_write(input beat_t b);
    int a;
    for (int i = 0; i < (1 << b.size); i++) begin
      a = int'(b.addr) + i;
      if (b.strb[a % 4]) mem_b[a] = b.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic drive_addr(input beat_t a);
    hsel = a.sel; htrans = a.trans; hwrite = a.write;
    haddr = a.addr; hsize = a.size; hburst = a.burst;
  endtask

  // Entered and left #1 after a rising edge. Advances on the model's ready, so it always drains.
  task automatic run_queue();
    beat_t a, d;
    int k;
    bit exp_rdy, exp_resp;
    logic [31:0] exp_rdata;
    d = idle_beat();
    k = 0;
    a = (q.size() > 0) ? q.pop_front() : idle_beat();
    forever begin
      drive_addr(a);
      hwdata = d.wdata;
      hwstrb = d.strb;
      @(negedge clk);
      if (!is_xfer(d)) begin
        exp_rdy = 1'b1; exp_resp = 1'b0; exp_rdata = 32'd0;
      end else if (is_err(d)) begin
        exp_rdy = (k == 1); exp_resp = 1'b1; exp_rdata = 32'd0;
      end else begin
        exp_rdy = (k == WAITS); exp_resp = 1'b0;
        exp_rdata = (exp_rdy && !d.write) ? model_word(d.addr) : 32'd0;
      end
      check_eq("hreadyout", 32'(hreadyout), 32'(exp_rdy));
      check_eq("hresp", 32'(hresp), 32'(exp_resp));
      check_eq("hrdata", hrdata, exp_rdata);
      check_eq("err_cnt", 32'(err_cnt), 32'(model_err));
      @(posedge clk);
      if (exp_rdy) begin
        if (is_xfer(d)) begin
          if (!is_err(d) && d.write) model_write(d);
          $display("%s addr=%h size=%0d data=%h resp=%s", d.write ? "WR" : "RD", d.addr,
                   d.size, d.write ? d.wdata : exp_rdata, is_err(d) ? "ERROR" : "OKAY");
        end
        d = a;
        k = 0;
        if (is_xfer(d) && is_err(d) && model_err < 65535) model_err++;
        a = (q.size() > 0) ? q.pop_front() : idle_beat();
      end else begin
        k++;
      end
      #1;
      if (q.size() == 0 && !is_xfer(a) && !is_xfer(d)) break;
    end
    drive_addr(idle_beat());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic [1:0] tr;
    logic [2:0] sz;
    logic [31:0] ad;
    int r;
    n_checks = 0; n_fail = 0; model_err = 0; ext_ready = 1'b1;
    drive_addr(idle_beat());
    hwdata = 32'd0; hwstrb = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp", 32'(hresp), 32'd0);
    check_eq("rst_hrdata", hrdata, 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give every word a defined value so later reads never see X.
    for (int i = 0; i < 64; i++) q.push_back(mk(1, T_NSEQ, 1, 32'(i * 4), 3'd2, $urandom, 4'hF, 3'd0));
    run_queue();

    q.push_back(mk(1, T_NSEQ, 1, 32'h10, 3'd2, 32'hA5A51234, 4'hF, 3'd0));
    q.push_back(mk(1, T_NSEQ, 0, 32'h10, 3'd2, 32'd0, 4'h0, 3'd0));
    q.push_back(mk(1, T_NSEQ, 1, 32'h13, 3'd0, 32'hEE000000, 4'hF, 3'd0));
    q.push_back(mk(1, T_NSEQ, 0, 32'h10, 3'd2, 32'd0, 4'h0, 3'd0));
    q.push_back(mk(1, T_NSEQ, 1, 32'h100, 3'd2, 32'hDEADBEEF, 4'hF, 3'd0));
    q.push_back(mk(1, T_NSEQ, 0, 32'h00, 3'd2, 32'd0, 4'h0, 3'd0));
    q.push_back(mk(1, T_NSEQ, 1, 32'h11, 3'd1, 32'hFFFFFFFF, 4'hF, 3'd0));
    q.push_back(mk(1, T_NSEQ, 0, 32'h10, 3'd2, 32'd0, 4'h0, 3'd0));
    q.push_back(mk(1, T_NSEQ, 1, 32'h20, 3'd2, 32'h11112222, 4'hF, 3'd3));
    q.push_back(mk(1, T_SEQ,  1, 32'h24, 3'd2, 32'h33334444, 4'hF, 3'd3));
    q.push_back(mk(1, T_BUSY, 1, 32'h28, 3'd2, 32'h0, 4'h0, 3'd3));
    q.push_back(mk(1, T_SEQ,  1, 32'h28, 3'd2, 32'h55556666, 4'hF, 3'd3));
    q.push_back(mk(1, T_SEQ,  1, 32'h2C, 3'd2, 32'h77778888, 4'hF, 3'd3));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, T_NSEQ, 0, 32'(32'h20 + 4 * i), 3'd2, 32'd0, 4'h0, 3'd0));
    run_queue();

    // External wait: a NONSEQ write presented while HREADY is low must be ignored.
    ext_ready = 1'b0;
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h44; hsize = 3'd2;
    hwdata = 32'h12345678; hwstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_eq("extwait_hreadyout", 32'(hreadyout), 32'd1);
      check_eq("extwait_hresp", 32'(hresp), 32'd0);
      @(posedge clk); #1;
    end
    ext_ready = 1'b1;
    drive_addr(idle_beat());
    q.push_back(mk(1, T_NSEQ, 0, 32'h44, 3'd2, 32'd0, 4'h0, 3'd0));
    run_queue();

    // Reset during the wait state of a write to 0x30 must discard the write.
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2; hburst = 3'd0;
    @(posedge clk); #1;
    drive_addr(idle_beat());
    hwdata = 32'h0BAD0BAD; hwstrb = 4'hF;
    @(negedge clk);
    check_eq("prerst_hreadyout", 32'(hreadyout), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("midrst_hresp", 32'(hresp), 32'd0);
    check_eq("midrst_hrdata", hrdata, 32'd0);
    check_eq("midrst_err_cnt", 32'(err_cnt), 32'd0);
    model_err = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(1, T_NSEQ, 0, 32'h30, 3'd2, 32'd0, 4'h0, 3'd0));
    run_queue();

    for (int n = 0; n < 100; n++) begin
      r  = $urandom_range(0, 9);
      tr = (r < 6) ? T_NSEQ : (r < 8) ? T_SEQ : (r < 9) ? T_BUSY : T_IDLE;
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      ad = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      b = mk($urandom_range(0, 7) != 0, tr, $urandom_range(0, 1) != 0, ad, sz,
             $urandom, 4'($urandom), 3'($urandom));
      q.push_back(b);
    end
    for (int i = 0; i < 64; i++) q.push_back(mk(1, T_NSEQ, 0, 32'(i * 4), 3'd2, 32'd0, 4'h0, 3'd0));
    run_queue();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
